// File: rtl/wt_mem_resp_pkg.sv
// rtl/wt_mem_resp_pkg.sv - shared types and geometry for the write-through memory responder
package wt_mem_resp_pkg;

    localparam int TidW  = 2;
    localparam int LineW = 128;
    localparam int DataW = 64;
    localparam int CntW  = 8;

    localparam int WordBytes    = DataW / 8;
    localparam int WordsPerLine = LineW / DataW;
    localparam int OffsetBits   = $clog2(WordBytes);

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_IFILL = 2'd2,
        REQ_RSVD  = 2'd3
    } req_type_e;

    typedef struct packed {
        req_type_e           rtype;
        logic [TidW-1:0]     tid;
        logic [LineW-1:0]    rdata;
        logic                err;
        logic [CntW-1:0]     cnt;
    } rsp_entry_t;

endpackage

// File: rtl/wt_mem_resp_fifo.sv
// rtl/wt_mem_resp_fifo.sv - pending-response fifo with per-entry latency countdown
module wt_mem_resp_fifo
    import wt_mem_resp_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  rsp_entry_t push_entry_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       head_ready_o,
    output rsp_entry_t head_entry_o
);

    localparam int PtrW = $clog2(Depth);

    rsp_entry_t       entries [Depth];
    logic [Depth-1:0] valid;
    logic [PtrW:0]    wr_ptr;
    logic [PtrW:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // extra pointer MSB distinguishes full from empty when the index bits match
    assign empty_o      = (wr_ptr == rd_ptr);
    assign full_o       = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                          (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign head_entry_o = entries[rd_ptr[PtrW-1:0]];
    assign head_ready_o = !empty_o && (head_entry_o.cnt == '0);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && head_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (valid[i] && entries[i].cnt != '0) begin
                    entries[i].cnt <= entries[i].cnt - 1'b1;
                end
            end
            if (do_pop) begin
                valid[rd_ptr[PtrW-1:0]] <= 1'b0;
                rd_ptr                  <= rd_ptr + 1'b1;
            end
            // a push never targets a live slot, so it cannot collide with the countdown above
            if (do_push) begin
                entries[wr_ptr[PtrW-1:0]] <= push_entry_i;
                valid[wr_ptr[PtrW-1:0]]   <= 1'b1;
                wr_ptr                    <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_mem_responder.sv
// rtl/wt_mem_responder.sv - tagged in-order memory responder with fixed latency and backing store
module wt_mem_responder
    import wt_mem_resp_pkg::*;
#(
    parameter int          MemTidWidth = 2,
    parameter int          LineWidth   = 128,
    parameter int          DataWidth   = 64,
    parameter logic [63:0] BaseAddr    = 64'h8000_0000,
    parameter int          NumWords    = 256,
    parameter int          Latency     = 2,
    parameter int          Outstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_type_i,
    input  logic [MemTidWidth-1:0] req_tid_i,
    input  logic [63:0]            req_paddr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_type_o,
    output logic [MemTidWidth-1:0] rsp_tid_o,
    output logic [LineWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o
);

    localparam int          IdxW        = $clog2(NumWords);
    localparam logic [63:0] RegionBytes = 64'(NumWords) * 64'(WordBytes);

    logic [DataWidth-1:0] mem [NumWords];

    req_type_e            req_type;
    logic [63:0]          offset;
    logic                 in_range;
    logic                 req_err;
    logic                 accept;
    logic [IdxW-1:0]      word_idx;
    logic [IdxW-1:0]      line_idx;
    logic [LineWidth-1:0] line_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_ready;
    rsp_entry_t           push_entry;
    rsp_entry_t           head_entry;

    assign req_type = req_type_e'(req_type_i);

    // compare on the unsigned difference so addresses below the base cannot wrap into range
    assign offset   = req_paddr_i - BaseAddr;
    assign in_range = (req_paddr_i >= BaseAddr) && (offset < RegionBytes);
    assign req_err  = !in_range || (req_type == REQ_RSVD);

    assign word_idx = offset[OffsetBits +: IdxW];
    assign line_idx = word_idx & ~IdxW'(WordsPerLine - 1);

    always_comb begin
        line_data = '0;
        for (int w = 0; w < WordsPerLine; w++) begin
            line_data[w*DataWidth +: DataWidth] = mem[line_idx + IdxW'(w)];
        end
    end

    assign req_ready_o = !fifo_full;
    assign accept      = req_valid_i && !fifo_full;

    // read data is captured at acceptance, which gives loads read-after-write ordering
    always_comb begin
        push_entry       = '0;
        push_entry.rtype = req_type;
        push_entry.tid   = req_tid_i;
        push_entry.err   = req_err;
        push_entry.rdata = (req_err || req_type == REQ_STORE) ? '0 : line_data;
        push_entry.cnt   = CntW'(Latency - 1);
    end

    always_ff @(posedge clk_i) begin
        if (accept && req_type == REQ_STORE && !req_err) begin
            for (int b = 0; b < WordBytes; b++) begin
                if (req_be_i[b]) begin
                    mem[word_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    wt_mem_resp_fifo #(
        .Depth        (Outstanding)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (accept),
        .push_entry_i (push_entry),
        .pop_i        (rsp_valid_o && rsp_ready_i),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_ready_o (head_ready),
        .head_entry_o (head_entry)
    );

    assign rsp_valid_o = head_ready && !fifo_empty && (head_entry.cnt == '0);
    assign rsp_type_o  = head_entry.rtype;
    assign rsp_tid_o   = head_entry.tid;
    assign rsp_rdata_o = head_entry.rdata;
    assign rsp_err_o   = head_entry.err;

endmodule

// File: tb/tb_wt_mem_responder.sv
// tb/tb_wt_mem_responder.sv - directed self-checking bench for wt_mem_responder
module tb_wt_mem_responder;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [1:0]   req_type_i = '0;
    logic [1:0]   req_tid_i = '0;
    logic [63:0]  req_paddr_i = '0;
    logic [63:0]  req_wdata_i = '0;
    logic [7:0]   req_be_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b1;
    logic [1:0]   rsp_type_o;
    logic [1:0]   rsp_tid_o;
    logic [127:0] rsp_rdata_o;
    logic         rsp_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] AllOnes = {128{1'b1}};

    always #5 clk_i = ~clk_i;

    wt_mem_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_type_i  (req_type_i),
        .req_tid_i   (req_tid_i),
        .req_paddr_i (req_paddr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_type_o  (rsp_type_o),
        .rsp_tid_o   (rsp_tid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [1:0] tid, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] be);
        req_valid_i = 1'b1;
        req_type_i  = t;
        req_tid_i   = tid;
        req_paddr_i = addr;
        req_wdata_i = wd;
        req_be_i    = be;
    endtask

    // one request on an idle responder, response consumed immediately; mask selects checked data bits
    task automatic txn(input string tag, input logic [1:0] t, input logic [1:0] tid,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] be,
                       input logic [127:0] exp_d, input logic [127:0] mask, input logic exp_e);
        int waited;
        int lat;
        @(negedge clk_i);
        drive(t, tid, addr, wd, be);
        waited = 0;
        while (!req_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'd2);
        check({tag, ".type"}, 128'(rsp_type_o), 128'(t));
        check({tag, ".tid"}, 128'(rsp_tid_o), 128'(tid));
        check({tag, ".err"}, 128'(rsp_err_o), 128'(exp_e));
        if (mask != '0) begin
            check({tag, ".rdata"}, rsp_rdata_o & mask, exp_d & mask);
        end
        @(posedge clk_i);
    endtask

    initial begin
        int got_n;
        int bound;
        logic stale;
        logic acc_now;
        logic [1:0] held_tid;
        logic [127:0] held_rdata;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst.req_ready", 128'(req_ready_o), 128'd1);
        check("rst.rsp_valid", 128'(rsp_valid_o), 128'd0);
        check("rst.rsp_type", 128'(rsp_type_o), 128'd0);
        check("rst.rsp_tid", 128'(rsp_tid_o), 128'd0);
        check("rst.rsp_rdata", rsp_rdata_o, 128'd0);
        check("rst.rsp_err", 128'(rsp_err_o), 128'd0);

        // store then load one cycle later: responses on consecutive cycles
        drive(2'd1, 2'd1, 64'h8000_0008, 64'h1122334455667788, 8'hFF);
        check("raw.accept", 128'(req_ready_o), 128'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(2'd0, 2'd2, 64'h8000_0000, 64'h0, 8'h00);
        check("raw.st_early", 128'(rsp_valid_o), 128'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("raw.st_valid", 128'(rsp_valid_o), 128'd1);
        check("raw.st_type", 128'(rsp_type_o), 128'd1);
        check("raw.st_tid", 128'(rsp_tid_o), 128'd1);
        check("raw.st_rdata", rsp_rdata_o, 128'd0);
        check("raw.st_err", 128'(rsp_err_o), 128'd0);
        @(negedge clk_i);
        check("raw.ld_valid", 128'(rsp_valid_o), 128'd1);
        check("raw.ld_type", 128'(rsp_type_o), 128'd0);
        check("raw.ld_tid", 128'(rsp_tid_o), 128'd2);
        check("raw.ld_hi", 128'(rsp_rdata_o[127:64]), 128'h1122334455667788);
        check("raw.ld_err", 128'(rsp_err_o), 128'd0);
        @(negedge clk_i);
        check("raw.drained", 128'(rsp_valid_o), 128'd0);

        // partial byte-enable store then ifill of the containing line
        txn("be.zero_lo", 2'd1, 2'd0, 64'h8000_0010, 64'h0, 8'hFF, 128'd0, AllOnes, 1'b0);
        txn("be.zero_hi", 2'd1, 2'd0, 64'h8000_0018, 64'h0, 8'hFF, 128'd0, AllOnes, 1'b0);
        txn("be.byte0", 2'd1, 2'd1, 64'h8000_0010, 64'h55555555555555AA, 8'h01, 128'd0, AllOnes, 1'b0);
        txn("be.ifill", 2'd2, 2'd3, 64'h8000_0018, 64'h0, 8'h00,
            {64'h0, 64'h00000000000000AA}, AllOnes, 1'b0);

        // range boundaries and reserved type
        txn("rng.init0", 2'd1, 2'd0, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 128'd0, AllOnes, 1'b0);
        txn("rng.init254", 2'd1, 2'd0, 64'h8000_07F0, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 128'd0, AllOnes, 1'b0);
        txn("rng.init255", 2'd1, 2'd0, 64'h8000_07F8, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 128'd0, AllOnes, 1'b0);
        txn("rng.ld_below", 2'd0, 2'd1, 64'h7FFF_FFF8, 64'h0, 8'h00, 128'd0, AllOnes, 1'b1);
        txn("rng.ld_above", 2'd0, 2'd2, 64'h8000_0800, 64'h0, 8'h00, 128'd0, AllOnes, 1'b1);
        txn("rng.st_above", 2'd1, 2'd3, 64'h8000_0800, 64'hDEADDEADDEADDEAD, 8'hFF, 128'd0, AllOnes, 1'b1);
        txn("rng.st_below", 2'd1, 2'd0, 64'h7FFF_FFF8, 64'hBEEFBEEFBEEFBEEF, 8'hFF, 128'd0, AllOnes, 1'b1);
        txn("rng.rsvd", 2'd3, 2'd1, 64'h8000_0000, 64'hCAFECAFECAFECAFE, 8'hFF, 128'd0, AllOnes, 1'b1);
        txn("rng.keep_lo", 2'd0, 2'd2, 64'h8000_0004, 64'h0, 8'h00,
            {64'h1122334455667788, 64'h0123456789ABCDEF}, AllOnes, 1'b0);
        txn("rng.keep_hi", 2'd0, 2'd3, 64'h8000_07F0, 64'h0, 8'h00,
            {64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5}, AllOnes, 1'b0);

        // backpressure: fill the fifo, hold outputs, then drain in order
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, 2'(k), 64'h8000_0000 + 64'(k * 16), 64'h0, 8'h00);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        drive(2'd0, 2'd0, 64'h8000_0010, 64'h0, 8'h00);
        check("bp.full", 128'(req_ready_o), 128'd0);
        @(negedge clk_i);
        check("bp.head_valid", 128'(rsp_valid_o), 128'd1);
        held_tid   = rsp_tid_o;
        held_rdata = rsp_rdata_o;
        check("bp.head_tid", 128'(held_tid), 128'd0);
        check("bp.head_rdata", held_rdata, {64'h1122334455667788, 64'h0123456789ABCDEF});
        repeat (3) @(negedge clk_i);
        check("bp.hold_valid", 128'(rsp_valid_o), 128'd1);
        check("bp.hold_tid", 128'(rsp_tid_o), 128'(held_tid));
        check("bp.hold_rdata", rsp_rdata_o, held_rdata);
        check("bp.still_full", 128'(req_ready_o), 128'd0);
        rsp_ready_i = 1'b1;
        got_n = 0;
        bound = 0;
        while (got_n < 5 && bound < 40) begin
            acc_now = req_valid_i && req_ready_o;
            if (rsp_valid_o) begin
                check($sformatf("bp.order%0d", got_n), 128'(rsp_tid_o), 128'(got_n % 4));
                got_n++;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            if (acc_now) begin
                req_valid_i = 1'b0;
            end
            bound++;
        end
        check("bp.count", 128'(got_n), 128'd5);
        check("bp.fifth_taken", 128'(req_valid_i), 128'd0);

        // reset with responses pending
        rsp_ready_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            drive(2'd0, 2'(k), 64'h8000_0000, 64'h0, 8'h00);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("rr.pending", 128'(rsp_valid_o), 128'd1);
        rst_i = 1'b1;
        #1;
        check("rr.async_valid", 128'(rsp_valid_o), 128'd0);
        check("rr.async_ready", 128'(req_ready_o), 128'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o) stale = 1'b1;
        end
        check("rr.no_stale", 128'(stale), 128'd0);
        txn("rr.fresh", 2'd0, 2'd2, 64'h8000_0000, 64'h0, 8'h00, 128'd0, 128'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
